// File: rtl/cla_share_ctrl.sv
// cla_share_ctrl: arbitrates two requesters onto one shared WIDTH-bit
// carry-lookahead adder. An accepted op takes one adder pass (narrow) or
// two (wide: low half, then high half with the carry chained), and the
// result is then held until the consumer takes it.
// Optional feature macro: CLA_SHARE_PERF_EN adds per-requester completed
// response counters (perf_cnt0_o / perf_cnt1_o).
module cla_share_ctrl #(
  parameter int WIDTH      = 16,
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid_i,
  output logic               req0_ready_o,
  input  logic               req0_sub_i,
  input  logic               req0_wide_i,
  input  logic [2*WIDTH-1:0] req0_a_i,
  input  logic [2*WIDTH-1:0] req0_b_i,
  input  logic               req1_valid_i,
  output logic               req1_ready_o,
  input  logic               req1_sub_i,
  input  logic               req1_wide_i,
  input  logic [2*WIDTH-1:0] req1_a_i,
  input  logic [2*WIDTH-1:0] req1_b_i,
  output logic [WIDTH-1:0]   add_p_o,
  output logic [WIDTH-1:0]   add_q_o,
  output logic               add_cin_o,
  input  logic [WIDTH-1:0]   add_sum_i,
  input  logic               add_cout_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic               rsp_id_o,
  output logic [2*WIDTH-1:0] rsp_sum_o,
  output logic               rsp_cout_o,
  output logic               rsp_ovf_o
`ifdef CLA_SHARE_PERF_EN
  ,
  output logic [15:0]        perf_cnt0_o,
  output logic [15:0]        perf_cnt1_o
`endif
);

  typedef enum logic [1:0] {IDLE, LO, HI, RSP} state_t;

  state_t             state_q;
  logic               lastGrant_q;
  logic [2*WIDTH-1:0] a_q;
  logic [2*WIDTH-1:0] b_q;
  logic               sub_q;
  logic               wide_q;
  logic               id_q;
  logic [WIDTH-1:0]   sumLo_q;
  logic [WIDTH-1:0]   sumHi_q;
  logic               carry_q;
  logic               ovf_q;

  logic               grantValid;
  logic               grantId;
  logic               passOvf;

  // Pick the requester to serve: a lone requester wins outright; on a tie
  // the one not served last time wins, unless req0 has fixed priority.
  always_comb begin
    grantValid = 1'b0;
    grantId    = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grantValid = 1'b1;
      grantId    = PRIO_FIXED ? 1'b0 : ~lastGrant_q;
    end else if (req0_valid_i) begin
      grantValid = 1'b1;
      grantId    = 1'b0;
    end else if (req1_valid_i) begin
      grantValid = 1'b1;
      grantId    = 1'b1;
    end
  end

  assign req0_ready_o = (state_q == IDLE) && grantValid && !grantId;
  assign req1_ready_o = (state_q == IDLE) && grantValid && grantId;

  // Feed the shared adder the half selected by the current pass; the adder
  // sees zeros whenever no pass is running. SUB is A + ~B + 1 on the first
  // pass, with the borrow chain carried into the high pass.
  always_comb begin
    add_p_o   = '0;
    add_q_o   = '0;
    add_cin_o = 1'b0;
    case (state_q)
      LO: begin
        add_p_o   = a_q[WIDTH-1:0];
        add_q_o   = b_q[WIDTH-1:0] ^ {WIDTH{sub_q}};
        add_cin_o = sub_q;
      end
      HI: begin
        add_p_o   = a_q[2*WIDTH-1:WIDTH];
        add_q_o   = b_q[2*WIDTH-1:WIDTH] ^ {WIDTH{sub_q}};
        add_cin_o = carry_q;
      end
      default: begin
        add_p_o   = '0;
        add_q_o   = '0;
        add_cin_o = 1'b0;
      end
    endcase
  end

  // Signed overflow of the pass in flight: like-signed operands producing a
  // result of the opposite sign.
  always_comb begin
    passOvf = (add_p_o[WIDTH-1] == add_q_o[WIDTH-1]) &&
              (add_sum_i[WIDTH-1] != add_p_o[WIDTH-1]);
  end

  // Sequencer: accept one op, run its adder pass(es), then hold the result
  // until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      wide_q      <= 1'b0;
      id_q        <= 1'b0;
      sumLo_q     <= '0;
      sumHi_q     <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grantValid) begin
            a_q         <= grantId ? req1_a_i : req0_a_i;
            b_q         <= grantId ? req1_b_i : req0_b_i;
            sub_q       <= grantId ? req1_sub_i : req0_sub_i;
            wide_q      <= grantId ? req1_wide_i : req0_wide_i;
            id_q        <= grantId;
            lastGrant_q <= grantId;
            state_q     <= LO;
          end
        end
        LO: begin
          sumLo_q <= add_sum_i;
          carry_q <= add_cout_i;
          ovf_q   <= passOvf;
          if (!wide_q) begin
            sumHi_q <= '0;
          end
          state_q <= wide_q ? HI : RSP;
        end
        HI: begin
          sumHi_q <= add_sum_i;
          carry_q <= add_cout_i;
          ovf_q   <= passOvf;
          state_q <= RSP;
        end
        RSP: begin
          if (rsp_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid_o = (state_q == RSP);
  assign rsp_id_o    = id_q;
  assign rsp_sum_o   = {sumHi_q, sumLo_q};
  assign rsp_cout_o  = carry_q;
  assign rsp_ovf_o   = ovf_q;

`ifdef CLA_SHARE_PERF_EN
  logic [15:0] perfCnt0_q;
  logic [15:0] perfCnt1_q;

  // Count completed responses per requester, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfCnt0_q <= '0;
      perfCnt1_q <= '0;
    end else if ((state_q == RSP) && rsp_ready_i) begin
      if (!id_q && (perfCnt0_q != 16'hFFFF)) begin
        perfCnt0_q <= perfCnt0_q + 16'd1;
      end
      if (id_q && (perfCnt1_q != 16'hFFFF)) begin
        perfCnt1_q <= perfCnt1_q + 16'd1;
      end
    end
  end

  assign perf_cnt0_o = perfCnt0_q;
  assign perf_cnt1_o = perfCnt1_q;
`endif

endmodule

// File: tb/tb_cla_share_ctrl.sv
// tb_cla_share_ctrl: directed bench for cla_share_ctrl with WIDTH=16.
// A behavioural adder stands in for the shared cla_16_bit instance. A second
// instance with fixed priority shares the request inputs so tie-breaking
// can be compared between the two arbitration modes.
module tb_cla_share_ctrl;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req0Valid = 1'b0, req0Sub = 1'b0, req0Wide = 1'b0;
  logic [2*W-1:0] req0A = '0, req0B = '0;
  logic          req1Valid = 1'b0, req1Sub = 1'b0, req1Wide = 1'b0;
  logic [2*W-1:0] req1A = '0, req1B = '0;
  logic          rspReady = 1'b1;

  logic          req0Ready, req1Ready;
  logic [W-1:0]  addP, addQ, addSum;
  logic          addCin, addCout;
  logic          rspValid, rspId, rspCout, rspOvf;
  logic [2*W-1:0] rspSum;

  logic          fReq0Ready, fReq1Ready;
  logic [W-1:0]  fAddP, fAddQ, fAddSum;
  logic          fAddCin, fAddCout;
  logic          fRspValid, fRspId, fRspCout, fRspOvf;
  logic [2*W-1:0] fRspSum;

`ifdef CLA_SHARE_PERF_EN
  logic [15:0]   perf0, perf1, fPerf0, fPerf1;
`endif

  logic [70:0]   allOut;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Shared adder models, one per instance
  assign {addCout, addSum}   = {1'b0, addP} + {1'b0, addQ} + {{W{1'b0}}, addCin};
  assign {fAddCout, fAddSum} = {1'b0, fAddP} + {1'b0, fAddQ} + {{W{1'b0}}, fAddCin};

  assign allOut = {addP, addQ, addCin, rspValid, rspSum, rspCout, rspOvf, rspId,
                   req0Ready, req1Ready};

  cla_share_ctrl #(.WIDTH(W), .PRIO_FIXED(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req0Valid), .req0_ready_o(req0Ready), .req0_sub_i(req0Sub),
    .req0_wide_i(req0Wide), .req0_a_i(req0A), .req0_b_i(req0B),
    .req1_valid_i(req1Valid), .req1_ready_o(req1Ready), .req1_sub_i(req1Sub),
    .req1_wide_i(req1Wide), .req1_a_i(req1A), .req1_b_i(req1B),
    .add_p_o(addP), .add_q_o(addQ), .add_cin_o(addCin),
    .add_sum_i(addSum), .add_cout_i(addCout),
    .rsp_valid_o(rspValid), .rsp_ready_i(rspReady), .rsp_id_o(rspId),
    .rsp_sum_o(rspSum), .rsp_cout_o(rspCout), .rsp_ovf_o(rspOvf)
`ifdef CLA_SHARE_PERF_EN
    , .perf_cnt0_o(perf0), .perf_cnt1_o(perf1)
`endif
  );

  cla_share_ctrl #(.WIDTH(W), .PRIO_FIXED(1'b1)) dutFixed (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req0Valid), .req0_ready_o(fReq0Ready), .req0_sub_i(req0Sub),
    .req0_wide_i(req0Wide), .req0_a_i(req0A), .req0_b_i(req0B),
    .req1_valid_i(req1Valid), .req1_ready_o(fReq1Ready), .req1_sub_i(req1Sub),
    .req1_wide_i(req1Wide), .req1_a_i(req1A), .req1_b_i(req1B),
    .add_p_o(fAddP), .add_q_o(fAddQ), .add_cin_o(fAddCin),
    .add_sum_i(fAddSum), .add_cout_i(fAddCout),
    .rsp_valid_o(fRspValid), .rsp_ready_i(rspReady), .rsp_id_o(fRspId),
    .rsp_sum_o(fRspSum), .rsp_cout_o(fRspCout), .rsp_ovf_o(fRspOvf)
`ifdef CLA_SHARE_PERF_EN
    , .perf_cnt0_o(fPerf0), .perf_cnt1_o(fPerf1)
`endif
  );

  // Issue one op from a single requester and wait for its response.
  // lat counts clock edges from the accept edge (as 1) to the edge after
  // which rsp_valid is seen.
  task automatic doOp(input logic id, input logic sub, input logic wide,
                      input logic [31:0] a, input logic [31:0] b,
                      output int lat, output logic [31:0] sum,
                      output logic cout, output logic ovf, output logic rid);
    int waitCnt;
    bit got;
    @(negedge clk);
    if (!id) begin
      req0Valid = 1'b1; req0Sub = sub; req0Wide = wide; req0A = a; req0B = b;
    end else begin
      req1Valid = 1'b1; req1Sub = sub; req1Wide = wide; req1A = a; req1B = b;
    end
    #1;
    waitCnt = 0;
    while (!(id ? req1Ready : req0Ready) && waitCnt < 20) begin
      @(negedge clk);
      #1;
      waitCnt++;
    end
    if (waitCnt >= 20) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout: ready never seen for req%0d", id);
    end
    @(posedge clk);
    #1;
    req0Valid = 1'b0; req1Valid = 1'b0;
    req0A = 32'hDEADBEEF; req0B = 32'hCAFEF00D; req0Sub = ~sub; req0Wide = ~wide;
    req1A = 32'h5A5A5A5A; req1B = 32'hA5A5A5A5; req1Sub = ~sub; req1Wide = ~wide;
    lat = 1;
    got = 1'b0;
    while (!got && lat < 10) begin
      if (rspValid) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("[TB] FAIL rsp_timeout: rsp_valid never seen for req%0d", id);
    end
    sum = rspSum; cout = rspCout; ovf = rspOvf; rid = rspId;
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (allOut !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h required 0", allOut);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_narrow_add();
    int lat; logic [31:0] s; logic c, o, id;
    doOp(1'b0, 1'b0, 1'b0, 32'h00001234, 32'h00000FFF, lat, s, c, o, id);
    checks++; if (s !== 32'h00002233) begin errors++; $display("[TB] FAIL add_sum: got %h required %h", s, 32'h00002233); end
    checks++; if (c !== 1'b0) begin errors++; $display("[TB] FAIL add_cout: got %b required 0", c); end
    checks++; if (o !== 1'b0) begin errors++; $display("[TB] FAIL add_ovf: got %b required 0", o); end
    checks++; if (id !== 1'b0) begin errors++; $display("[TB] FAIL add_id: got %b required 0", id); end
    checks++; if (lat != 2) begin errors++; $display("[TB] FAIL add_latency: got %0d required 2", lat); end
  endtask

  task automatic test_wide_add();
    int lat; logic [31:0] s; logic c, o, id;
    doOp(1'b1, 1'b0, 1'b1, 32'h0000FFFF, 32'h00000001, lat, s, c, o, id);
    checks++; if (s !== 32'h00010000) begin errors++; $display("[TB] FAIL wide_sum: got %h required %h", s, 32'h00010000); end
    checks++; if (c !== 1'b0) begin errors++; $display("[TB] FAIL wide_cout: got %b required 0", c); end
    checks++; if (o !== 1'b0) begin errors++; $display("[TB] FAIL wide_ovf: got %b required 0", o); end
    checks++; if (id !== 1'b1) begin errors++; $display("[TB] FAIL wide_id: got %b required 1", id); end
    checks++; if (lat != 3) begin errors++; $display("[TB] FAIL wide_latency: got %0d required 3", lat); end
  endtask

  task automatic test_sub();
    int lat; logic [31:0] s; logic c, o, id;
    // Upper operand halves are junk and must not reach a narrow result
    doOp(1'b0, 1'b1, 1'b0, 32'hABCD0005, 32'h12340007, lat, s, c, o, id);
    checks++; if ({s, c, o} !== {32'h0000FFFE, 1'b0, 1'b0}) begin errors++; $display("[TB] FAIL sub_5_7: got sum=%h cout=%b ovf=%b required sum=0000fffe cout=0 ovf=0", s, c, o); end
    doOp(1'b1, 1'b1, 1'b0, 32'h00008000, 32'h00000001, lat, s, c, o, id);
    checks++; if ({s, c, o} !== {32'h00007FFF, 1'b1, 1'b1}) begin errors++; $display("[TB] FAIL sub_8000_1: got sum=%h cout=%b ovf=%b required sum=00007fff cout=1 ovf=1", s, c, o); end
    doOp(1'b0, 1'b1, 1'b1, 32'h00000000, 32'h00000001, lat, s, c, o, id);
    checks++; if ({s, c, o} !== {32'hFFFFFFFF, 1'b0, 1'b0}) begin errors++; $display("[TB] FAIL sub_wide_0_1: got sum=%h cout=%b ovf=%b required sum=ffffffff cout=0 ovf=0", s, c, o); end
    checks++; if (lat != 3) begin errors++; $display("[TB] FAIL sub_wide_latency: got %0d required 3", lat); end
  endtask

  task automatic test_arbitration();
    logic mainGrant [4];
    logic fixGrant [4];
    int   mainCyc [4];
    int   nM, nF, bothReady;
    logic expMain [4];
    expMain[0] = 1'b0; expMain[1] = 1'b1; expMain[2] = 1'b0; expMain[3] = 1'b1;
    nM = 0; nF = 0; bothReady = 0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req0Valid = 1'b1; req0Sub = 1'b0; req0Wide = 1'b0; req0A = 32'd1; req0B = 32'd2;
    req1Valid = 1'b1; req1Sub = 1'b0; req1Wide = 1'b0; req1A = 32'd3; req1B = 32'd4;
    for (int cyc = 0; cyc < 40 && (nM < 4 || nF < 4); cyc++) begin
      #1;
      if ((req0Ready && req1Ready) || (fReq0Ready && fReq1Ready)) bothReady++;
      if ((req0Ready || req1Ready) && nM < 4) begin
        mainGrant[nM] = req1Ready; mainCyc[nM] = cyc; nM++;
      end
      if ((fReq0Ready || fReq1Ready) && nF < 4) begin
        fixGrant[nF] = fReq1Ready; nF++;
      end
      @(negedge clk);
    end
    checks++;
    if (nM != 4 || nF != 4) begin
      errors++;
      $display("[TB] FAIL arb_grant_count: got rr=%0d fixed=%0d required 4 each", nM, nF);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (mainGrant[i] !== expMain[i]) begin errors++; $display("[TB] FAIL rr_grant%0d: got %b required %b", i, mainGrant[i], expMain[i]); end
        checks++;
        if (fixGrant[i] !== 1'b0) begin errors++; $display("[TB] FAIL fixed_grant%0d: got %b required 0", i, fixGrant[i]); end
      end
      checks++;
      if (mainCyc[1] - mainCyc[0] != 3) begin errors++; $display("[TB] FAIL issue_interval: got %0d required 3", mainCyc[1] - mainCyc[0]); end
    end
    checks++;
    if (bothReady != 0) begin errors++; $display("[TB] FAIL ready_exclusive: got %0d cycles with both ready required 0", bothReady); end
    req0Valid = 1'b0; req1Valid = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_rsp_stall();
    int lat; logic [31:0] s; logic c, o, id;
    rspReady = 1'b0;
    doOp(1'b1, 1'b0, 1'b0, 32'h00000100, 32'h00000023, lat, s, c, o, id);
    checks++; if (s !== 32'h00000123) begin errors++; $display("[TB] FAIL stall_sum: got %h required 00000123", s); end
    req0Valid = 1'b1; req0Sub = 1'b0; req0Wide = 1'b0; req0A = 32'h7; req0B = 32'h8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({rspValid, rspId, rspSum, req0Ready, req1Ready} !== {1'b1, 1'b1, 32'h00000123, 1'b0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: got valid=%b id=%b sum=%h rdy0=%b rdy1=%b required valid=1 id=1 sum=00000123 rdy0=0 rdy1=0",
                 i, rspValid, rspId, rspSum, req0Ready, req1Ready);
      end
    end
    @(negedge clk);
    rspReady = 1'b1;
    req0Valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rspValid !== 1'b0) begin errors++; $display("[TB] FAIL stall_release: got rsp_valid=%b required 0", rspValid); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int waitCnt;
    @(negedge clk);
    req0Valid = 1'b1; req0Sub = 1'b0; req0Wide = 1'b1; req0A = 32'h12345678; req0B = 32'h11111111;
    @(posedge clk);
    #1;
    req0Valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({addP, addQ, addCin} !== {16'h1234, 16'h1111, 1'b0}) begin
      errors++;
      $display("[TB] FAIL hi_pass_drive: got p=%h q=%h cin=%b required p=1234 q=1111 cin=0", addP, addQ, addCin);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (allOut !== '0) begin errors++; $display("[TB] FAIL reset_mid_hi: got %h required 0", allOut); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rspValid !== 1'b0) begin errors++; $display("[TB] FAIL stale_rsp: got rsp_valid=%b required 0", rspValid); end
    @(negedge clk);
    req0Valid = 1'b1; req0Sub = 1'b0; req0Wide = 1'b0; req0A = 32'h10; req0B = 32'h20;
    req1Valid = 1'b1; req1Sub = 1'b0; req1Wide = 1'b0; req1A = 32'h40; req1B = 32'h01;
    #1;
    checks++;
    if ({req0Ready, req1Ready} !== 2'b10) begin errors++; $display("[TB] FAIL post_reset_grant: got rdy0=%b rdy1=%b required rdy0=1 rdy1=0", req0Ready, req1Ready); end
    @(posedge clk);
    #1;
    req0Valid = 1'b0; req1Valid = 1'b0;
    waitCnt = 0;
    while (!rspValid && waitCnt < 10) begin
      @(posedge clk);
      #1;
      waitCnt++;
    end
    checks++;
    if ({rspValid, rspId, rspSum} !== {1'b1, 1'b0, 32'h00000030}) begin
      errors++;
      $display("[TB] FAIL post_reset_rsp: got valid=%b id=%b sum=%h required valid=1 id=0 sum=00000030", rspValid, rspId, rspSum);
    end
    repeat (3) @(negedge clk);
  endtask

  // Run every scenario in order, then report.
  initial begin
    $display("[TB] start");
    test_reset();
    test_narrow_add();
    test_wide_add();
    test_sub();
    test_arbitration();
    test_rsp_stall();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
